// File: rtl/demux_sched.sv
// demux_sched: round-robin scheduler driving the E/s1/s2 inputs of a 1-to-4
// demultiplexer. It grants one requesting channel at a time for at most
// HOLD_MAX cycles. Consecutive grants are separated by one E-low cycle.
// All outputs come straight from flops, so the demux selects never glitch.
//
// State table:
//   state | meaning
//   IDLE  | no grant; E=0, busy=0, selects keep their last value
//   GRANT | channel {s2,s1} owns the demux; E=1
//   GAP   | one E-low cycle after a grant; grant_done=1, re-arbitrate
//
// Ports:
//   clk         in   system clock, rising edge
//   rst         in   synchronous reset, active high
//   en          in   global enable; low blocks new grants and ends a grant
//   req[3:0]    in   level requests, bit n = channel n
//   E           out  demux enable, high while a grant is active
//   s1, s2      out  channel select LSB / MSB
//   busy        out  high whenever the state is not IDLE
//   grant_done  out  one-cycle pulse in the cycle after a grant ends
module demux_sched #(
    parameter int HOLD_MAX = 8,
    parameter int CW       = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [3:0] req,
    output logic       E,
    output logic       s1,
    output logic       s2,
    output logic       busy,
    output logic       grant_done
);

    typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

    localparam logic [CW-1:0] HOLD_LIM = CW'(HOLD_MAX);

    state_t        state;
    logic [1:0]    last;
    logic [CW-1:0] cnt;
    logic [1:0]    pick;
    logic          pick_vld;
    logic [1:0]    cand;
    logic [1:0]    ch;
    logic          release_grant;

    // Scan upward from the channel after the last one granted, wrapping at 3,
    // so a channel that keeps requesting waits for every other requester.
    always_comb begin
        pick     = '0;
        pick_vld = 1'b0;
        cand     = '0;
        for (int i = 0; i < 4; i++) begin
            cand = last + 2'(i + 1);
            if (!pick_vld && req[cand]) begin
                pick     = cand;
                pick_vld = 1'b1;
            end
        end
    end

    assign ch            = {s2, s1};
    assign release_grant = !req[ch] || (cnt == HOLD_LIM) || !en;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            E          <= 1'b0;
            s1         <= 1'b0;
            s2         <= 1'b0;
            busy       <= 1'b0;
            grant_done <= 1'b0;
            last       <= 2'd3;
            cnt        <= '0;
        end else begin
            grant_done <= 1'b0;
            unique case (state)
                IDLE, GAP: begin
                    if (en && pick_vld) begin
                        state    <= GRANT;
                        E        <= 1'b1;
                        {s2, s1} <= pick;
                        last     <= pick;
                        cnt      <= CW'(1);
                        busy     <= 1'b1;
                    end else begin
                        // Selects are deliberately left alone here.
                        state <= IDLE;
                        E     <= 1'b0;
                        busy  <= 1'b0;
                    end
                end
                GRANT: begin
                    if (release_grant) begin
                        state      <= GAP;
                        E          <= 1'b0;
                        grant_done <= 1'b1;
                        busy       <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    E     <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_demux_sched.sv
// Bench for demux_sched. Four instances with HOLD_MAX = 4, 2, 8 and 1 share
// the same stimulus; each scenario compares the instance it targets.
// Expected outputs per cycle are pushed to a queue with the stimulus and
// popped after each clock edge.
module tb_demux_sched;

    typedef struct packed {
        logic       rst;
        logic       en;
        logic [3:0] req;
    } stim_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b0;
    logic [3:0] req = 4'b0000;

    wire [3:0] e_v, s1_v, s2_v, busy_v, gd_v;

    int total = 0;
    int bad   = 0;

    stim_t      sq[$];
    logic [4:0] eq[$];

    always #5 clk = ~clk;

    // index 0: HOLD_MAX=4, 1: HOLD_MAX=2, 2: HOLD_MAX=8, 3: HOLD_MAX=1
    demux_sched #(.HOLD_MAX(4), .CW(8)) u_h4 (
        .clk(clk), .rst(rst), .en(en), .req(req), .E(e_v[0]), .s1(s1_v[0]),
        .s2(s2_v[0]), .busy(busy_v[0]), .grant_done(gd_v[0]));
    demux_sched #(.HOLD_MAX(2), .CW(8)) u_h2 (
        .clk(clk), .rst(rst), .en(en), .req(req), .E(e_v[1]), .s1(s1_v[1]),
        .s2(s2_v[1]), .busy(busy_v[1]), .grant_done(gd_v[1]));
    demux_sched #(.HOLD_MAX(8), .CW(8)) u_h8 (
        .clk(clk), .rst(rst), .en(en), .req(req), .E(e_v[2]), .s1(s1_v[2]),
        .s2(s2_v[2]), .busy(busy_v[2]), .grant_done(gd_v[2]));
    demux_sched #(.HOLD_MAX(1), .CW(8)) u_h1 (
        .clk(clk), .rst(rst), .en(en), .req(req), .E(e_v[3]), .s1(s1_v[3]),
        .s2(s2_v[3]), .busy(busy_v[3]), .grant_done(gd_v[3]));

    // {E, s2, s1, busy, grant_done}
    function automatic logic [4:0] obs(input int k);
        return {e_v[k], s2_v[k], s1_v[k], busy_v[k], gd_v[k]};
    endfunction

    function automatic logic [4:0] ex(input logic e, input int ch, input logic b, input logic g);
        logic [1:0] c;
        c = 2'(ch);
        return {e, c[1], c[0], b, g};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic r, input logic n, input logic [3:0] q, input logic [4:0] e);
        stim_t s;
        s.rst = r;
        s.en  = n;
        s.req = q;
        sq.push_back(s);
        eq.push_back(e);
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        en  = 1'b0;
        req = 4'b0000;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        en  = 1'b1;
        req = 4'b1111;
        tick();
        tick();
        for (int k = 0; k < 4; k++) begin
            total++;
            if (obs(k) !== 5'b00000) begin
                bad++;
                $display("FAIL reset inst%0d: got E,s2,s1,busy,gd=%b expected 00000", k, obs(k));
            end
        end
        rst = 1'b0;
    endtask

    // HOLD_MAX=4, ch2 held: 4 high, 1 gap, 4 high, 1 gap
    task automatic test_hold();
        stim_t s;
        logic [4:0] exp, got;
        apply_reset();
        for (int g = 0; g < 2; g++) begin
            for (int c = 0; c < 4; c++) push(1'b0, 1'b1, 4'b0100, ex(1'b1, 2, 1'b1, 1'b0));
            push(1'b0, 1'b1, 4'b0100, ex(1'b0, 2, 1'b1, 1'b1));
        end
        for (int i = 0; sq.size() > 0; i++) begin
            s = sq.pop_front(); rst = s.rst; en = s.en; req = s.req;
            tick();
            exp = eq.pop_front(); got = obs(0); total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL hold cyc%0d: got E,s2,s1,busy,gd=%b expected %b", i, got, exp);
            end
        end
    endtask

    // HOLD_MAX=2, all requesting: order 0,1,2,3,0
    task automatic test_round_robin();
        stim_t s;
        logic [4:0] exp, got;
        apply_reset();
        for (int k = 0; k < 5; k++) begin
            push(1'b0, 1'b1, 4'b1111, ex(1'b1, k % 4, 1'b1, 1'b0));
            push(1'b0, 1'b1, 4'b1111, ex(1'b1, k % 4, 1'b1, 1'b0));
            push(1'b0, 1'b1, 4'b1111, ex(1'b0, k % 4, 1'b1, 1'b1));
        end
        for (int i = 0; sq.size() > 0; i++) begin
            s = sq.pop_front(); rst = s.rst; en = s.en; req = s.req;
            tick();
            exp = eq.pop_front(); got = obs(1); total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL round_robin cyc%0d: got E,s2,s1,busy,gd=%b expected %b", i, got, exp);
            end
        end
    endtask

    // HOLD_MAX=8, ch1 requests for 3 cycles then drops
    task automatic test_req_drop();
        stim_t s;
        logic [4:0] exp, got;
        apply_reset();
        for (int c = 0; c < 3; c++) push(1'b0, 1'b1, 4'b0010, ex(1'b1, 1, 1'b1, 1'b0));
        push(1'b0, 1'b1, 4'b0000, ex(1'b0, 1, 1'b1, 1'b1));
        push(1'b0, 1'b1, 4'b0000, ex(1'b0, 1, 1'b0, 1'b0));
        push(1'b0, 1'b1, 4'b0000, ex(1'b0, 1, 1'b0, 1'b0));
        for (int i = 0; sq.size() > 0; i++) begin
            s = sq.pop_front(); rst = s.rst; en = s.en; req = s.req;
            tick();
            exp = eq.pop_front(); got = obs(2); total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL req_drop cyc%0d: got E,s2,s1,busy,gd=%b expected %b", i, got, exp);
            end
        end
    endtask

    // HOLD_MAX=8, ch1 grant ended by en, no grants while en=0, then ch2 next
    task automatic test_en_drop();
        stim_t s;
        logic [4:0] exp, got;
        apply_reset();
        push(1'b0, 1'b1, 4'b0010, ex(1'b1, 1, 1'b1, 1'b0));
        push(1'b0, 1'b1, 4'b0010, ex(1'b1, 1, 1'b1, 1'b0));
        push(1'b0, 1'b0, 4'b1111, ex(1'b0, 1, 1'b1, 1'b1));
        for (int c = 0; c < 3; c++) push(1'b0, 1'b0, 4'b1111, ex(1'b0, 1, 1'b0, 1'b0));
        push(1'b0, 1'b1, 4'b1111, ex(1'b1, 2, 1'b1, 1'b0));
        for (int i = 0; sq.size() > 0; i++) begin
            s = sq.pop_front(); rst = s.rst; en = s.en; req = s.req;
            tick();
            exp = eq.pop_front(); got = obs(2); total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL en_drop cyc%0d: got E,s2,s1,busy,gd=%b expected %b", i, got, exp);
            end
        end
    endtask

    // HOLD_MAX=8, rst during 3rd cycle of ch3 grant; then ch0 wins over ch3
    task automatic test_rst_mid();
        stim_t s;
        logic [4:0] exp, got;
        apply_reset();
        for (int c = 0; c < 3; c++) push(1'b0, 1'b1, 4'b1000, ex(1'b1, 3, 1'b1, 1'b0));
        push(1'b1, 1'b1, 4'b1000, ex(1'b0, 0, 1'b0, 1'b0));
        push(1'b0, 1'b1, 4'b1001, ex(1'b1, 0, 1'b1, 1'b0));
        push(1'b0, 1'b1, 4'b1001, ex(1'b1, 0, 1'b1, 1'b0));
        for (int i = 0; sq.size() > 0; i++) begin
            s = sq.pop_front(); rst = s.rst; en = s.en; req = s.req;
            tick();
            exp = eq.pop_front(); got = obs(2); total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL rst_mid cyc%0d: got E,s2,s1,busy,gd=%b expected %b", i, got, exp);
            end
        end
    endtask

    // HOLD_MAX=1, ch0 held: single-cycle grants alternating with gaps
    task automatic test_hold_one();
        stim_t s;
        logic [4:0] exp, got;
        apply_reset();
        for (int c = 0; c < 4; c++) begin
            push(1'b0, 1'b1, 4'b0001, ex(1'b1, 0, 1'b1, 1'b0));
            push(1'b0, 1'b1, 4'b0001, ex(1'b0, 0, 1'b1, 1'b1));
        end
        for (int i = 0; sq.size() > 0; i++) begin
            s = sq.pop_front(); rst = s.rst; en = s.en; req = s.req;
            tick();
            exp = eq.pop_front(); got = obs(3); total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL hold_one cyc%0d: got E,s2,s1,busy,gd=%b expected %b", i, got, exp);
            end
        end
    endtask

    // HOLD_MAX=8, ch0 granted, others join: no preemption, full hold, then ch1
    task automatic test_no_preempt();
        stim_t s;
        logic [4:0] exp, got;
        apply_reset();
        push(1'b0, 1'b1, 4'b0001, ex(1'b1, 0, 1'b1, 1'b0));
        for (int c = 0; c < 7; c++) push(1'b0, 1'b1, 4'b1111, ex(1'b1, 0, 1'b1, 1'b0));
        push(1'b0, 1'b1, 4'b1111, ex(1'b0, 0, 1'b1, 1'b1));
        push(1'b0, 1'b1, 4'b1111, ex(1'b1, 1, 1'b1, 1'b0));
        for (int i = 0; sq.size() > 0; i++) begin
            s = sq.pop_front(); rst = s.rst; en = s.en; req = s.req;
            tick();
            exp = eq.pop_front(); got = obs(2); total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL no_preempt cyc%0d: got E,s2,s1,busy,gd=%b expected %b", i, got, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_hold();
        test_round_robin();
        test_req_drop();
        test_en_drop();
        test_rst_mid();
        test_hold_one();
        test_no_preempt();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/demux_sched.md
Name: demux_sched

Overview:
Round-robin scheduler that sits directly upstream of the 1-to-4 procedural demultiplexer and drives its E, s1 and s2 inputs. Four requesters raise level requests. The block grants one channel at a time for a bounded number of cycles. It presents the channel index on s2/s1 and asserts E for the duration of the grant. All outputs are registered so the demux sees glitch-free selects.

Parameters:
HOLD_MAX, 8, maximum consecutive cycles E stays high per grant; legal range 1..255
CW, 8, width of internal hold counter; must satisfy 2^CW > HOLD_MAX

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  synchronous reset, active-high
en  input  1  global enable; 0 blocks new grants and ends an active grant
req  input  4  level requests, bit n = channel n
E  output  1  demux enable; high while a grant is active
s1  output  1  channel select LSB
s2  output  1  channel select MSB
busy  output  1  high whenever state is not IDLE
grant_done  output  1  single-cycle pulse on the cycle after a grant ends

Behaviour:
- Interface: one clock (clk). Reset (rst) is synchronous and active-high, sampled on the rising edge of clk.
- Reset values:
  - E=0, s1=0, s2=0, busy=0, grant_done=0.
  - State is IDLE, counter is 0.
  - Last-granted pointer is 3, so channel 0 has first priority.
- States: IDLE, GRANT, GAP. All outputs are registered.
- Arbitration (evaluated in IDLE and GAP):
  - If en=1 and req!=0, pick the first set bit scanning from (last+1) mod 4 upward, wrapping 3->0.
  - Next edge: state=GRANT, E=1, {s2,s1}=channel, last=channel, cnt=1, busy=1.
- IDLE:
  - No valid request, or en=0: stay IDLE. E=0 and busy=0.
  - s2/s1 hold their previous value; they are not cleared.
- GRANT (release check on each edge):
  - Release condition: req[ch]=0, or cnt==HOLD_MAX, or en=0.
  - On release: state=GAP, E=0, grant_done=1 for exactly that one cycle, busy stays 1.
  - Otherwise cnt=cnt+1, E stays 1.
  - s2/s1 stay stable for the whole grant and through GAP.
- GAP: exactly one cycle with E=0.
  - Run arbitration: if a request wins, go to GRANT next edge; otherwise go to IDLE (busy=0).
  - Back-to-back grants are therefore separated by exactly one E-low cycle.
- Latency: a request sampled in IDLE gives E=1 on the following cycle (1-cycle latency).
- Hold length: E is high for min(HOLD_MAX, cycles until req[ch] is sampled low) cycles. HOLD_MAX=1 gives single-cycle grants.
- Request changes mid-grant:
  - Requests from other channels do not preempt the active grant.
  - req[ch] dropping ends the grant at the next edge.
- Simultaneous release condition and rst: rst wins and all reset values apply.
- rst mid-grant: E falls the next edge, no grant_done pulse, pointer returns to 3.
- Fairness: a channel that keeps its request asserted is re-granted only after every other requesting channel has had a turn.

Test Plan:
1. HOLD_MAX=4, req=4'b0100 held, en=1 -> E high 4 cycles with {s2,s1}=2'b10; grant_done pulses once; one E-low cycle; ch2 re-granted for another 4 cycles.
2. req=4'b1111 held, HOLD_MAX=2 -> grant order 0,1,2,3,0. Each grant is 2 E-high cycles separated by 1 E-low cycle; s2/s1 step 00,01,10,11,00.
3. req=4'b0010 asserted 3 cycles then dropped, HOLD_MAX=8 -> E high 3 cycles with {s2,s1}=01; grant_done pulse; then IDLE, busy=0.
4. Grant active on ch1, en dropped at cycle 2 -> E low next edge, grant_done pulse, GAP then IDLE; no new grant while en=0 despite req=4'b1111.
5. rst asserted on the 3rd cycle of a ch3 grant -> next edge E=0, s1=s2=0, busy=0, no grant_done. After rst is released with req=4'b1001, channel 0 is granted first.
6. HOLD_MAX=1, req=4'b0001 held -> E alternates 1,0,1,0 with {s2,s1}=00; grant_done high on every E-low cycle.
